// File: rtl/m_word_streamer.sv
// Streams NUM_WORDS modulus words out of the m_mem ROM onto a valid/ready port, hiding the ROM read latency behind a small credit-managed FIFO.
// Optional: define M_STREAM_REVERSE_EN to add a `reverse` input that walks the ROM from the top address down.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 16
`endif

module m_word_streamer #(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int NUM_WORDS    = `TOTAL_ADDR,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
`ifdef M_STREAM_REVERSE_EN
  input  logic                  reverse,
`endif
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  word_last,
  output logic [ADDR_WIDTH-1:0] word_index,
  output logic                  busy,
  output logic                  done
);
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ORD = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   iss_q, iss_d;   // ordinal of the next address to issue
  logic [ADDR_WIDTH-1:0]   ord_q, ord_d;   // ordinal of the FIFO head
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0]   fifo_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    rev_q, start_rev;
  logic                    push, pop, issue, flush;
  logic [OW-1:0]           infl_n, occ;

`ifdef M_STREAM_REVERSE_EN
  assign start_rev = reverse;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                  rev_q <= 1'b0;
    else if (state_q == S_IDLE && start && !abort) rev_q <= reverse;
  end
`else
  assign start_rev = 1'b0;
  assign rev_q     = 1'b0;
`endif

  // Credits: words queued plus words still inside the ROM pipeline.
  always_comb begin
    infl_n = '0;
    for (int i = 0; i < READ_LATENCY; i++) infl_n = infl_n + OW'(vld_pipe_q[i]);
  end

  assign pop   = word_valid & word_ready;
  assign push  = vld_pipe_q[READ_LATENCY-1];
  assign occ   = OW'(cnt_q) + infl_n - OW'(pop);
  assign issue = (state_q == S_RUN) && (occ < OW'(DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    ord_d   = ord_q;
    done_d  = 1'b0;
    flush   = 1'b0;
    if (pop) ord_d = ord_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          iss_d   = '0;
          ord_d   = '0;
          addr_d  = start_rev ? LAST_ORD : '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          iss_d  = iss_q + 1'b1;
          addr_d = rev_q ? addr_q - 1'b1 : addr_q + 1'b1;
          if (iss_q == LAST_ORD) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && word_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ord_d   = '0;
      flush   = 1'b1;
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    assign vld_pipe_d = flush ? '0 : {vld_pipe_q[READ_LATENCY-2:0], issue};
  end else begin : g_pipe1
    assign vld_pipe_d = issue & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      iss_q      <= '0;
      ord_q      <= '0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_q      <= iss_d;
      ord_q      <= ord_d;
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push && !flush) begin
      fifo_q[wr_ptr_q] <= mem_q;
    end
  end

  assign mem_addr   = addr_q;
  assign word_valid = (cnt_q != '0);
  assign word_data  = fifo_q[rd_ptr_q];
  assign word_index = ord_q;
  assign word_last  = word_valid && (ord_q == LAST_ORD);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  // Credit accounting guarantees a slot for every tagged ROM word.
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && !pop && !flush && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_m_word_streamer.sv
// Scoreboarded bench for m_word_streamer: ROM model, random backpressure/aborts, directed timing checks.
module tb_m_word_streamer;
  localparam int AW = 4, DW = 16, NW = 4, RL = 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int vecs = 0, errs = 0;

  logic start = 1'b0, abort = 1'b0, rev = 1'b0, word_ready;
  logic [AW-1:0] mem_addr, word_index, addr_r;
  logic [DW-1:0] mem_q, word_data;
  logic word_valid, word_last, busy, done;
  logic [DW-1:0] rom [16];

  m_word_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .READ_LATENCY(RL)) dut (
    .clock(clock), .resetn(resetn), .start(start),
`ifdef M_STREAM_REVERSE_EN
    .reverse(rev),
`endif
    .abort(abort), .mem_addr(mem_addr), .mem_q(mem_q), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
    .word_index(word_index), .busy(busy), .done(done));

  // ROM: registered address, registered output
  always @(posedge clock) begin
    addr_r <= mem_addr;
    mem_q  <= rom[addr_r];
  end

  // Single-word instance
  logic s1 = 1'b0, ab1 = 1'b0, rdy1 = 1'b1;
  logic [AW-1:0] a1, i1, ar1;
  logic [DW-1:0] q1, d1;
  logic v1, l1, b1, dn1;

  m_word_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(1), .READ_LATENCY(RL)) u1 (
    .clock(clock), .resetn(resetn), .start(s1),
`ifdef M_STREAM_REVERSE_EN
    .reverse(1'b0),
`endif
    .abort(ab1), .mem_addr(a1), .mem_q(q1), .word_data(d1),
    .word_valid(v1), .word_ready(rdy1), .word_last(l1),
    .word_index(i1), .busy(b1), .done(dn1));

  always @(posedge clock) begin
    ar1 <= a1;
    q1  <= (ar1 == '0) ? 16'h5A5A : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  int rmode = 0;
  int rc = 0;
  always @(posedge clock) begin
    #1;
    rc++;
    case (rmode)
      0:       word_ready = 1'b1;
      1:       word_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
      default: word_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct {
    logic [DW-1:0] d;
    int            idx;
    bit            last;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard monitor with a transaction-level model of busy/done
  logic mbusy = 1'b0, pv = 1'b0, pr = 1'b0, pab = 1'b0, plh = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] pi = '0;
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      exp_q.delete();
      mbusy = 1'b0; pv = 1'b0; pab = 1'b0; plh = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(mbusy));
      chk("done", 32'(done), 32'(plh & ~pab));
      if (!mbusy) chk("idle_valid", 32'(word_valid), 32'd0);
      if (pv && !pr && !pab) begin
        chk("hold_valid", 32'(word_valid), 32'd1);
        chk("hold_data", 32'(word_data), 32'(pd));
        chk("hold_index", 32'(word_index), 32'(pi));
        chk("hold_last", 32'(word_last), 32'(pl));
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL extra_word: got data %0h, expected no word", word_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(word_data), 32'(e.d));
          chk("word_index", 32'(word_index), 32'(e.idx));
          chk("word_last", 32'(word_last), 32'(e.last));
        end
      end
      plh = word_valid & word_ready & word_last;
      pab = abort; pv = word_valid; pr = word_ready;
      pd = word_data; pi = word_index; pl = word_last;
      if (abort) begin
        exp_q.delete();
        mbusy = 1'b0;
      end else if (start && !mbusy) begin
        mbusy = 1'b1;
        for (int k = 0; k < NW; k++) begin
          e.d    = rom[rev ? NW - 1 - k : k];
          e.idx  = k;
          e.last = (k == NW - 1);
          exp_q.push_back(e);
        end
      end else if (plh) begin
        mbusy = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 300);
    if (n >= 300) begin
      vecs++; errs++;
      $display("FAIL timeout: busy=%0b pending=%0d, expected idle", busy, exp_q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic run_stream(input int abort_at);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
    end
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(word_data), 32'd0);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_last"}, 32'(word_last), 32'd0);
    chk({tag, "_index"}, 32'(word_index), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = DW'(16'hA0 + i);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("rst");
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Timing: start in cycles 0, 2 (ignored) and 8 (done cycle restart)
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t_valid", 32'(word_valid), 32'(c >= 4 && c <= 7));
      chk("t_last", 32'(word_last), 32'(c == 7));
      chk("t_done", 32'(done), 32'(c == 8));
      chk("t_busy", 32'(busy), 32'(c >= 1 && c != 8));
      if (c >= 4 && c <= 7) chk("t_data", 32'(word_data), 32'(16'hA0 + c - 4));
      @(posedge clock); #1;
      start = (c + 1 == 2) || (c + 1 == 8);
    end
    start = 1'b0;
    wait_idle();

    // Backpressure 1,0,0,1
    rmode = 1;
    run_stream(-1);
    rmode = 0;

    // Abort in cycle 5
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 abort = 1'b1;
    @(negedge clock);
    chk("ab_pending", 32'(word_valid), 32'd1);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("ab_valid", 32'(word_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    run_stream(-1);

`ifdef M_STREAM_REVERSE_EN
    rev = 1'b1;
    run_stream(-1);
    rev = 1'b0;
`endif

    // Randomized streams
    rmode = 2;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
`ifdef M_STREAM_REVERSE_EN
      rev = 1'($urandom_range(0, 1));
`endif
      run_stream(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end
    rev = 1'b0;

    // Async reset mid-stream
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2 resetn = 1'b0;
    #1 chk_zero("mid_rst");
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    rmode = 0;
    run_stream(-1);

    // NUM_WORDS = 1
    s1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      chk("n1_valid", 32'(v1), 32'(c == 4));
      chk("n1_last", 32'(l1), 32'(c == 4));
      chk("n1_done", 32'(dn1), 32'(c == 5));
      chk("n1_busy", 32'(b1), 32'(c >= 1 && c <= 4));
      if (c == 4) chk("n1_data", 32'(d1), 32'h5A5A);
      @(posedge clock); #1;
      s1 = 1'b0;
    end

    chk("leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
